// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control encodings, flag bit positions and the
//                arbiter state type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam logic [2:0] ALU_PASSB = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b011;
   localparam logic [2:0] ALU_AND   = 3'b100;
   localparam logic [2:0] ALU_OR    = 3'b101;
   localparam logic [2:0] ALU_XOR   = 3'b110;

   // Bit positions within the {N,Z,V,C} flag nibble.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic [1:0] req,
   input  logic       en,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one combinational ALU between execute stage and the
//                address/branch unit; registered issue and response paths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int CTRL_W = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [2*WIDTH-1:0]    req_A,
   input  logic [2*WIDTH-1:0]    req_B,
   input  logic [2*CTRL_W-1:0]   req_cntrl,
   output logic [WIDTH-1:0]      alu_A,
   output logic [WIDTH-1:0]      alu_B,
   output logic [CTRL_W-1:0]     alu_cntrl,
   input  logic [WIDTH-1:0]      alu_result,
   input  logic [3:0]            alu_flags,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [WIDTH-1:0]      rsp_result,
   output logic [3:0]            rsp_flags
);

   alu_state_t          r_state;
   logic                r_last_grant;
   logic                r_issue_id;
   logic [WIDTH-1:0]    r_alu_A;
   logic [WIDTH-1:0]    r_alu_B;
   logic [CTRL_W-1:0]   r_alu_cntrl;
   logic                r_rsp_valid;
   logic                r_rsp_id;
   logic [WIDTH-1:0]    r_rsp_result;
   logic [3:0]          r_rsp_flags;

   logic                w_can_accept;
   logic [1:0]          w_grant;
   logic                w_accept;
   logic                w_gidx;
   logic [WIDTH-1:0]    w_sel_A;
   logic [WIDTH-1:0]    w_sel_B;
   logic [CTRL_W-1:0]   w_sel_cntrl;

   // A pending response frees the slot in the same edge it is consumed.
   assign w_can_accept = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);

   rr_arb2 u_rr_arb2 (
      .req        (req_valid),
      .en         (w_can_accept),
      .last_grant (r_last_grant),
      .grant      (w_grant)
   );

   assign w_accept    = |w_grant;
   assign w_gidx      = w_grant[1];
   assign w_sel_A     = w_gidx ? req_A[2*WIDTH-1:WIDTH]      : req_A[WIDTH-1:0];
   assign w_sel_B     = w_gidx ? req_B[2*WIDTH-1:WIDTH]      : req_B[WIDTH-1:0];
   assign w_sel_cntrl = w_gidx ? req_cntrl[2*CTRL_W-1:CTRL_W] : req_cntrl[CTRL_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_issue_id   <= 1'b0;
         r_alu_A      <= '0;
         r_alu_B      <= '0;
         r_alu_cntrl  <= CTRL_W'(ALU_PASSB);
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
      end else begin
         // Grant is already gated by can_accept, so this only fires in IDLE/RESP.
         if (w_accept) begin
            r_alu_A      <= w_sel_A;
            r_alu_B      <= w_sel_B;
            r_alu_cntrl  <= w_sel_cntrl;
            r_issue_id   <= w_gidx;
            r_last_grant <= w_gidx;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               r_rsp_result <= alu_result;
               r_rsp_flags  <= alu_flags;
               r_rsp_id     <= r_issue_id;
               r_rsp_valid  <= 1'b1;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= w_accept ? ST_EXEC : ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = w_grant;
   assign alu_A      = r_alu_A;
   assign alu_B      = r_alu_B;
   assign alu_cntrl  = r_alu_cntrl;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_flags  = r_rsp_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench with a reference ALU beside the arbiter
//                and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;
   import alu_pkg::*;

   localparam int WIDTH  = 64;
   localparam int CTRL_W = 3;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [2*WIDTH-1:0]   req_A;
   logic [2*WIDTH-1:0]   req_B;
   logic [2*CTRL_W-1:0]  req_cntrl;
   logic [WIDTH-1:0]     alu_A;
   logic [WIDTH-1:0]     alu_B;
   logic [CTRL_W-1:0]    alu_cntrl;
   logic [WIDTH-1:0]     alu_result;
   logic [3:0]           alu_flags;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_id;
   logic [WIDTH-1:0]     rsp_result;
   logic [3:0]           rsp_flags;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        r;
      logic [2:0]  c;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic [3:0]  fl;
   } vec_t;

   typedef struct {
      logic        id;
      logic [63:0] res;
      logic [3:0]  fl;
   } exp_t;

   vec_t tbl[9];
   exp_t sbq[$];

   alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_A      (req_A),
      .req_B      (req_B),
      .req_cntrl  (req_cntrl),
      .alu_A      (alu_A),
      .alu_B      (alu_B),
      .alu_cntrl  (alu_cntrl),
      .alu_result (alu_result),
      .alu_flags  (alu_flags),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags)
   );

   always #5 clk = ~clk;

   // Reference ALU: returns {N,Z,V,C, result}; carry on subtract means no borrow.
   function automatic logic [67:0] alu_model(input logic [2:0] c, input logic [63:0] a,
                                             input logic [63:0] b);
      logic [64:0] s;
      logic [63:0] r;
      logic        cy;
      logic        v;
      s  = '0;
      r  = '0;
      cy = 1'b0;
      v  = 1'b0;
      case (c)
         ALU_ADD: begin
            s  = {1'b0, a} + {1'b0, b};
            r  = s[63:0];
            cy = s[64];
            v  = (a[63] == b[63]) && (r[63] != a[63]);
         end
         ALU_SUB: begin
            s  = {1'b0, a} + {1'b0, ~b} + 65'd1;
            r  = s[63:0];
            cy = s[64];
            v  = (a[63] != b[63]) && (r[63] != a[63]);
         end
         ALU_AND:   r = a & b;
         ALU_OR:    r = a | b;
         ALU_XOR:   r = a ^ b;
         ALU_PASSB: r = b;
         default:   r = '0;
      endcase
      return {r[63], (r == 64'd0), v, cy, r};
   endfunction

   always_comb {alu_flags, alu_result} = alu_model(alu_cntrl, alu_A, alu_B);

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard consumer: a response is taken at the edge following this sample.
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (sbq.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_result", rsp_result, e.res);
            check("rsp_flags", 64'(rsp_flags), 64'(e.fl));
         end
      end
   end

   task automatic set_req(input logic r, input logic [2:0] c, input logic [63:0] a,
                          input logic [63:0] b);
      req_A[r*WIDTH +: WIDTH]       = a;
      req_B[r*WIDTH +: WIDTH]       = b;
      req_cntrl[r*CTRL_W +: CTRL_W] = c;
      req_valid[r]                  = 1'b1;
   endtask

   task automatic issue(input vec_t v);
      int n;
      @(posedge clk); #1;
      set_req(v.r, v.c, v.a, v.b);
      n = 0;
      @(negedge clk);
      while (!req_ready[v.r] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[v.r]) begin
         check("accept_timeout", 64'd1, 64'd0);
         req_valid[v.r] = 1'b0;
         return;
      end
      check("ready_onehot", 64'(req_ready), 64'(2'b01 << v.r));
      sbq.push_back('{v.r, v.res, v.fl});
      @(posedge clk); #1;
      req_valid[v.r] = 1'b0;
      check("issue_A", alu_A, v.a);
      check("issue_B", alu_B, v.b);
      check("issue_cntrl", 64'(alu_cntrl), 64'(v.c));
      @(negedge clk);
      check("exec_no_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("rsp_latency", 64'(rsp_valid), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        g;
      logic        eg;
      int          last;
      int          nacc;
      int          n;
      logic [67:0] m;

      tbl[0] = '{1'b0, ALU_XOR,   64'h1010101010101010, 64'h0101010101010101, 64'h1111111111111111, 4'b0000};
      tbl[1] = '{1'b1, ALU_ADD,   64'hFFFFFFFFFFFFFFFF, 64'd1,                64'd0,                4'b0101};
      tbl[2] = '{1'b0, ALU_SUB,   64'd5,                64'd5,                64'd0,                4'b0101};
      tbl[3] = '{1'b1, ALU_AND,   64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hF000F000F000F000, 4'b1000};
      tbl[4] = '{1'b0, ALU_OR,    64'd0,                64'd0,                64'd0,                4'b0100};
      tbl[5] = '{1'b1, ALU_PASSB, 64'd123,              64'h8000000000000000, 64'h8000000000000000, 4'b1000};
      tbl[6] = '{1'b0, ALU_ADD,   64'h7FFFFFFFFFFFFFFF, 64'd1,                64'h8000000000000000, 4'b1010};
      tbl[7] = '{1'b1, ALU_SUB,   64'd0,                64'd1,                64'hFFFFFFFFFFFFFFFF, 4'b1000};
      tbl[8] = '{1'b0, 3'b111,    64'hDEAD,             64'hBEEF,             64'd0,                4'b0100};

      reset     = 1'b1;
      req_valid = 2'b00;
      req_A     = '0;
      req_B     = '0;
      req_cntrl = '0;
      rsp_ready = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_alu_cntrl", 64'(alu_cntrl), 64'd0);
      check("rst_rsp_result", rsp_result, 64'd0);
      check("rst_rsp_flags", 64'(rsp_flags), 64'd0);
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      check("rst_alu_A", alu_A, 64'd0);

      // Single-requester vectors, consumer always ready.
      rsp_ready = 1'b1;
      foreach (tbl[i]) issue(tbl[i]);

      // Stalled consumer: response held; queued request waits, then goes on the RESP edge.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      set_req(1'b1, ALU_ADD, 64'hFFFFFFFFFFFFFFFF, 64'd1);
      n = 0;
      @(negedge clk);
      while (!req_ready[1] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("hold_accept", 64'(req_ready), 64'b10);
      sbq.push_back('{1'b1, 64'd0, 4'b0101});
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      set_req(1'b0, ALU_SUB, 64'd5, 64'd5);
      @(negedge clk);
      check("hold_exec_ready", 64'(req_ready), 64'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_valid", 64'(rsp_valid), 64'd1);
         check("hold_result", rsp_result, 64'd0);
         check("hold_flags", 64'(rsp_flags), 64'b0101);
         check("hold_id", 64'(rsp_id), 64'd1);
         check("hold_no_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("b2b_accept", 64'(req_ready), 64'b01);
      sbq.push_back('{1'b0, 64'd0, 4'b0101});
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("b2b_exec", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("b2b_rsp", 64'(rsp_valid), 64'd1);

      // Reset while an operation is in EXEC: it must vanish.
      @(posedge clk); #1;
      set_req(1'b0, ALU_XOR, 64'hAAAA, 64'h5555);
      @(negedge clk);
      check("pre_rst_accept", 64'(req_ready), 64'b01);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      end

      // Both requesting every cycle: tie goes to req0 first, then alternates.
      @(posedge clk); #1;
      set_req(1'b0, ALU_ADD, 64'd3, 64'd4);
      set_req(1'b1, ALU_XOR, 64'h00FF, 64'h0F0F);
      @(negedge clk);
      check("tie_after_reset", 64'(req_ready), 64'b01);
      eg   = 1'b0;
      last = -1;
      nacc = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (|(req_ready & req_valid)) begin
            g = req_ready[1];
            check("alt_grant", 64'(g), 64'(eg));
            if (last >= 0) check("alt_spacing", 64'(cyc - last), 64'd2);
            eg   = ~eg;
            last = cyc;
            nacc++;
            m = alu_model(req_cntrl[g*CTRL_W +: CTRL_W], req_A[g*WIDTH +: WIDTH],
                          req_B[g*WIDTH +: WIDTH]);
            sbq.push_back('{g, m[63:0], m[67:64]});
         end
         @(posedge clk); #1;
         if (cyc == 15) req_valid = 2'b00;
         @(negedge clk);
      end
      check("alt_accept_count", 64'(nacc), 64'd8);

      n = 0;
      while (sbq.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 64'(sbq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
